// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg : shared widths, ALU operation codes and ALU-class codes           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int XLEN    = 64;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_OP_AND = 4'b0000,
    ALU_OP_OR  = 4'b0001,
    ALU_OP_ADD = 4'b0010,
    ALU_OP_XOR = 4'b0011,
    ALU_OP_SLL = 4'b0100,
    ALU_OP_SRL = 4'b0101,
    ALU_OP_SUB = 4'b0110,
    ALU_OP_SRA = 4'b0111,
    ALU_OP_NOR = 4'b1100,
    ALU_OP_NOP = 4'b1111
  } alu_oper_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_RSVD   = 2'b11
  } alu_class_e;

  // funct = {instr[30], instr[14:12]}
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b1000;
  localparam logic [3:0] FUNCT_AND = 4'b0111;
  localparam logic [3:0] FUNCT_OR  = 4'b0110;
  localparam logic [3:0] FUNCT_XOR = 4'b0100;
  localparam logic [3:0] FUNCT_SLL = 4'b0001;
  localparam logic [3:0] FUNCT_SRL = 4'b0101;
  localparam logic [3:0] FUNCT_SRA = 4'b1101;

endpackage

`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
// +----------------------------------------------------------------------------+
// | alu_exec_unit_if : EX-stage operand/control bundle and registered results  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_exec_unit_if #(
  parameter int XLEN = alu_pkg::XLEN
);

  logic            in_valid;
  logic [1:0]      alu_op;
  logic [3:0]      funct;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;

  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            pos;
  logic [XLEN-1:0] branch_target;
  logic [3:0]      operation;

  modport master (
    output in_valid, alu_op, funct, op_a, op_b, pc, imm,
    input  out_valid, result, zero, pos, branch_target, operation
  );

  modport slave (
    input  in_valid, alu_op, funct, op_a, op_b, pc, imm,
    output out_valid, result, zero, pos, branch_target, operation
  );

endinterface

`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
// +----------------------------------------------------------------------------+
// | alu_ctrl_dec : combinational alu_op/funct -> ALU operation decode          |
// | Optional shift/XOR decode enabled by ALU_EXT_OPS_EN.  Revision: 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [3:0] funct,
  output alu_oper_e  operation
);

  always_comb begin
    operation = ALU_OP_NOP;
    case (alu_op)
      ALUOP_MEM:    operation = ALU_OP_ADD;
      ALUOP_BRANCH: operation = ALU_OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: operation = ALU_OP_ADD;
          FUNCT_SUB: operation = ALU_OP_SUB;
          FUNCT_AND: operation = ALU_OP_AND;
          FUNCT_OR:  operation = ALU_OP_OR;
`ifdef ALU_EXT_OPS_EN
          FUNCT_XOR: operation = ALU_OP_XOR;
          FUNCT_SLL: operation = ALU_OP_SLL;
          FUNCT_SRL: operation = ALU_OP_SRL;
          FUNCT_SRA: operation = ALU_OP_SRA;
`endif
          default:   operation = ALU_OP_NOP;
        endcase
      end
      default:      operation = ALU_OP_NOP;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// +----------------------------------------------------------------------------+
// | alu_exec_unit : EX-stage ALU, signed compare and branch-target adder with  |
// | one registered output stage. Extended ops via ALU_EXT_OPS_EN. Rev: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_exec_unit
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  alu_oper_e       w_operation;
  logic [XLEN-1:0] w_result;
  logic            w_zero;
  logic            w_pos;
  logic [XLEN-1:0] w_target;

  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_pos;
  logic [XLEN-1:0] r_target;
  logic [3:0]      r_operation;

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op    (bus.alu_op),
    .funct     (bus.funct),
    .operation (w_operation)
  );

`ifdef ALU_EXT_OPS_EN
  logic [SHAMT_W-1:0] w_shamt;
  assign w_shamt = bus.op_b[SHAMT_W-1:0];
`endif

  always_comb begin
    w_result = '0;
    case (w_operation)
      ALU_OP_AND: w_result = bus.op_a & bus.op_b;
      ALU_OP_OR:  w_result = bus.op_a | bus.op_b;
      ALU_OP_ADD: w_result = bus.op_a + bus.op_b;
      ALU_OP_SUB: w_result = bus.op_a - bus.op_b;
      ALU_OP_NOR: w_result = ~(bus.op_a | bus.op_b);
`ifdef ALU_EXT_OPS_EN
      ALU_OP_XOR: w_result = bus.op_a ^ bus.op_b;
      ALU_OP_SLL: w_result = bus.op_a << w_shamt;
      ALU_OP_SRL: w_result = bus.op_a >> w_shamt;
      ALU_OP_SRA: w_result = $unsigned($signed(bus.op_a) >>> w_shamt);
`endif
      default:    w_result = '0;
    endcase
  end

  // pos looks at the raw operands so branch logic sees it whatever the decode.
  assign w_zero   = (w_result == '0);
  assign w_pos    = ($signed(bus.op_a) >= $signed(bus.op_b));
  assign w_target = bus.pc + (bus.imm << 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_pos       <= 1'b0;
      r_target    <= '0;
      r_operation <= 4'b0000;
    end else if (bus.in_valid) begin
      r_out_valid <= 1'b1;
      r_result    <= w_result;
      r_zero      <= w_zero;
      r_pos       <= w_pos;
      r_target    <= w_target;
      r_operation <= w_operation;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.result        = r_result;
  assign bus.zero          = r_zero;
  assign bus.pos           = r_pos;
  assign bus.branch_target = r_target;
  assign bus.operation     = r_operation;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// +----------------------------------------------------------------------------+
// | tb_alu_exec_unit : directed and randomized checks against a reference model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_exec_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected registered state
  logic        m_valid;
  logic [63:0] m_res;
  logic        m_zero;
  logic        m_pos;
  logic [63:0] m_tgt;
  logic [3:0]  m_op;

  function automatic void model(input logic [1:0] aop, input logic [3:0] f,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [3:0] op, output logic [63:0] r);
    op = 4'b1111;
    r  = 64'd0;
    if (aop == 2'd0) begin op = 4'b0010; r = a + b; end
    else if (aop == 2'd1) begin op = 4'b0110; r = a - b; end
    else if (aop == 2'd2) begin
      if (f == 4'd0)       begin op = 4'b0010; r = a + b; end
      else if (f == 4'd8)  begin op = 4'b0110; r = a - b; end
      else if (f == 4'd7)  begin op = 4'b0000; r = a & b; end
      else if (f == 4'd6)  begin op = 4'b0001; r = a | b; end
`ifdef ALU_EXT_OPS_EN
      else if (f == 4'd4)  begin op = 4'b0011; r = a ^ b; end
      else if (f == 4'd1)  begin op = 4'b0100; r = a << b[5:0]; end
      else if (f == 4'd5)  begin op = 4'b0101; r = a >> b[5:0]; end
      else if (f == 4'd13) begin op = 4'b0111; r = $signed(a) >>> b[5:0]; end
`endif
    end
  endfunction

  task automatic drive(input logic rst_n, input logic v, input logic [1:0] aop,
                       input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] p, input logic [63:0] i);
    logic [3:0]  op;
    logic [63:0] r;
    reset        = rst_n;
    bus.in_valid = v;
    bus.alu_op   = aop;
    bus.funct    = f;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.pc       = p;
    bus.imm      = i;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 0; m_res = 0; m_zero = 0; m_pos = 0; m_tgt = 0; m_op = 0;
    end else if (v) begin
      model(aop, f, a, b, op, r);
      m_valid = 1'b1;
      m_res   = r;
      m_zero  = (r == 64'd0);
      m_pos   = ($signed(a) >= $signed(b));
      m_tgt   = p + i * 64'd2;
      m_op    = op;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    drive(1'b0, 1'b1, 2'd0, 4'd0, rnd64(), rnd64(), rnd64(), rnd64());
    drive(1'b0, 1'b1, 2'd2, 4'd7, rnd64(), rnd64(), rnd64(), rnd64());
    checks++;
    if ({bus.out_valid, bus.result, bus.zero, bus.pos, bus.branch_target, bus.operation} !== 135'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%h z=%b p=%b t=%h op=%b want all zero",
               bus.out_valid, bus.result, bus.zero, bus.pos, bus.branch_target, bus.operation);
    end
  endtask

  task automatic test_directed();
    drive(1'b1, 1'b1, 2'd0, 4'd3, 64'd10, 64'd32, 64'd0, 64'd0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 64'd42 || bus.operation !== 4'b0010 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL add_10_32 got v=%b r=%0d op=%b z=%b want v=1 r=42 op=0010 z=0",
               bus.out_valid, bus.result, bus.operation, bus.zero);
    end
    drive(1'b1, 1'b1, 2'd2, 4'b1000, 64'd5, 64'd5, 64'd0, 64'd0);
    checks++;
    if (bus.result !== 64'd0 || bus.zero !== 1'b1 || bus.pos !== 1'b1 || bus.operation !== 4'b0110) begin
      errors++;
      $display("FAIL sub_eq got r=%h z=%b p=%b op=%b want r=0 z=1 p=1 op=0110",
               bus.result, bus.zero, bus.pos, bus.operation);
    end
    drive(1'b1, 1'b1, 2'd1, 4'd0, -64'sd3, 64'd2, 64'd0, 64'd0);
    checks++;
    if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFB || bus.zero !== 1'b0 || bus.pos !== 1'b0) begin
      errors++;
      $display("FAIL branch_sub got r=%h z=%b p=%b want r=fffffffffffffffb z=0 p=0",
               bus.result, bus.zero, bus.pos);
    end
    drive(1'b1, 1'b1, 2'd2, 4'b0111, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0);
    checks++;
    if (bus.result !== 64'h00F0 || bus.operation !== 4'b0000) begin
      errors++;
      $display("FAIL and got r=%h op=%b want r=00f0 op=0000", bus.result, bus.operation);
    end
    drive(1'b1, 1'b1, 2'd2, 4'b0110, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0);
    checks++;
    if (bus.result !== 64'hFFF0 || bus.operation !== 4'b0001) begin
      errors++;
      $display("FAIL or got r=%h op=%b want r=fff0 op=0001", bus.result, bus.operation);
    end
    drive(1'b1, 1'b1, 2'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, -64'sd8);
    checks++;
    if (bus.result !== 64'd0 || bus.zero !== 1'b1 || bus.branch_target !== 64'hF0) begin
      errors++;
      $display("FAIL add_wrap_target got r=%h z=%b t=%h want r=0 z=1 t=f0",
               bus.result, bus.zero, bus.branch_target);
    end
    // in_valid low: data holds, out_valid drops
    drive(1'b1, 1'b0, 2'd0, 4'd0, 64'd7, 64'd7, 64'd0, 64'd0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 64'd0 || bus.zero !== 1'b1 || bus.branch_target !== 64'hF0) begin
      errors++;
      $display("FAIL hold got v=%b r=%h z=%b t=%h want v=0 r=0 z=1 t=f0",
               bus.out_valid, bus.result, bus.zero, bus.branch_target);
    end
    drive(1'b1, 1'b1, 2'd3, 4'd0, 64'd9, 64'd4, 64'd0, 64'd0);
    checks++;
    if (bus.result !== 64'd0 || bus.zero !== 1'b1 || bus.operation !== 4'b1111 || bus.pos !== 1'b1) begin
      errors++;
      $display("FAIL nop_class got r=%h z=%b op=%b p=%b want r=0 z=1 op=1111 p=1",
               bus.result, bus.zero, bus.operation, bus.pos);
    end
    drive(1'b1, 1'b1, 2'd2, 4'b0001, 64'd1, 64'd63, 64'd0, 64'd0);
    checks++;
`ifdef ALU_EXT_OPS_EN
    if (bus.result !== 64'h8000_0000_0000_0000 || bus.operation !== 4'b0100 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL sll_63 got r=%h op=%b z=%b want r=8000000000000000 op=0100 z=0",
               bus.result, bus.operation, bus.zero);
    end
`else
    if (bus.result !== 64'd0 || bus.operation !== 4'b1111 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL sll_disabled got r=%h op=%b z=%b want r=0 op=1111 z=1",
               bus.result, bus.operation, bus.zero);
    end
`endif
  endtask

  task automatic check_model(input string name);
    logic [134:0] got;
    logic [134:0] exp;
    got = {bus.out_valid, bus.result, bus.zero, bus.pos, bus.branch_target, bus.operation};
    exp = {m_valid, m_res, m_zero, m_pos, m_tgt, m_op};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  function automatic void pick_operands(output logic [63:0] a, output logic [63:0] b);
    case ($urandom_range(0, 3))
      0: begin a = rnd64(); b = rnd64(); end
      1: begin a = rnd64(); b = a; end
      2: begin a = 64'($urandom_range(0, 70)); b = 64'($urandom_range(0, 70)); end
      default: begin
        a = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        b = ($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64();
      end
    endcase
  endfunction

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] b;
    for (int n = 0; n < 300; n++) begin
      pick_operands(a, b);
      drive(1'b1, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            a, b, rnd64(), rnd64());
      check_model("random");
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    logic [63:0] b;
    for (int n = 0; n < 100; n++) begin
      pick_operands(a, b);
      drive(1'b1, 1'b1, 2'd2, 4'($urandom_range(0, 15)), a, b, rnd64(), rnd64());
      check_model("back_to_back");
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 2'd0, 4'd0, 64'd100, 64'd23, 64'd4, 64'd2);
    check_model("pre_reset");
    drive(1'b0, 1'b1, 2'd1, 4'd0, 64'd50, 64'd1, 64'd8, 64'd8);
    checks++;
    if ({bus.out_valid, bus.result, bus.branch_target, bus.operation} !== 133'd0) begin
      errors++;
      $display("FAIL reset_mid got v=%b r=%h t=%h op=%b want all zero",
               bus.out_valid, bus.result, bus.branch_target, bus.operation);
    end
    drive(1'b1, 1'b0, 2'd0, 4'd0, 64'd1, 64'd1, 64'd0, 64'd0);
    check_model("post_reset_idle");
    drive(1'b1, 1'b1, 2'd2, 4'b1000, 64'd20, 64'd30, 64'h200, 64'd4);
    check_model("post_reset_first");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_valid = 0; m_res = 0; m_zero = 0; m_pos = 0; m_tgt = 0; m_op = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_op = 2'd0;
    bus.funct = 4'd0;
    bus.op_a = 64'd0;
    bus.op_b = 64'd0;
    bus.pc = 64'd0;
    bus.imm = 64'd0;
    #2;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
